// File: rtl/ifid_stage.sv
// ---------------------------------------------------------------------------
// ifid_stage
//
// Pipeline register between fetch and decode. Each cycle it latches the
// fetched instruction with its PC and PC+1. It also handles stall (hold),
// flush (squash to NOP) and HALT detection. When a HALT enters the pipeline
// it raises halt_fetch so the fetch stage freezes its PC.
//
// Encodings:
//   NOP  = 16'h0800
//   HALT = any instruction with instr[15:11] == 5'b00000
//
// Ports:
//   clk          in   1   clock, all state updates on the rising edge
//   rst          in   1   synchronous, active-high reset
//   instr_in     in  16   instruction from fetch
//   pc_in        in  16   PC of instr_in
//   pcplus1_in   in  16   PC+1 of instr_in
//   stall        in   1   hold all register contents
//   flush        in   1   squash the latched instruction (taken branch/jump)
//   instr_out    out 16   instruction to decode
//   pc_out       out 16   latched PC
//   pcplus1_out  out 16   latched PC+1
//   valid_out    out  1   instr_out is a real instruction, not a bubble
//   halt_fetch   out  1   freezes the fetch-stage PC
//   stall_cnt    out 16   stalled-cycle counter (0 unless IFID_PERF_CNT_EN)
//   flush_cnt    out 16   flush counter        (0 unless IFID_PERF_CNT_EN)
//
// Build option:
//   IFID_PERF_CNT_EN  when defined, builds the saturating stall/flush
//                     counters. When undefined, both outputs are tied to 0.
// ---------------------------------------------------------------------------
module ifid_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_in,
    input  logic [15:0] pcplus1_in,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic [15:0] pcplus1_out,
    output logic        valid_out,
    output logic        halt_fetch,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [15:0] NOP = 16'h0800;

    // RUN:    normal loading.
    // DRAIN:  HALT latched; the one instruction fetched after it is dropped.
    // HALTED: frozen until a flush or a reset.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pcplus1_q, pcplus1_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;
    logic        in_is_halt;

    assign in_is_halt = (instr_in[15:11] == 5'b00000);

    // Priority: flush > stall > state action. Reset is applied in the
    // register process below.
    always_comb begin
        // NOTE: every signal gets a hold default first. This way, no path
        // through the branches leaves a variable unassigned and infers a latch.
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus1_d = pcplus1_q;
        valid_d   = valid_q;
        halt_d    = halt_q;

        if (flush) begin
            // A flush squashes the instruction but keeps the PCs. It also
            // cancels any HALT younger than the branch.
            instr_d = NOP;
            valid_d = 1'b0;
            state_d = ST_RUN;
            halt_d  = 1'b0;
        end else if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    instr_d   = instr_in;
                    pc_d      = pc_in;
                    pcplus1_d = pcplus1_in;
                    valid_d   = 1'b1;
                    if (in_is_halt) begin
                        state_d = ST_DRAIN;
                        halt_d  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Fetch advances once more before it sees halt_fetch.
                    // That one post-HALT instruction is discarded here.
                    instr_d = NOP;
                    valid_d = 1'b0;
                    state_d = ST_HALTED;
                end
                ST_HALTED: begin
                    // Hold everything until flush or reset.
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update together from pre-edge values, independent of order.
        if (rst) begin
            state_q   <= ST_RUN;
            instr_q   <= NOP;
            pc_q      <= '0;
            pcplus1_q <= '0;
            valid_q   <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus1_q <= pcplus1_d;
            valid_q   <= valid_d;
            halt_q    <= halt_d;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign pcplus1_out = pcplus1_q;
    assign valid_out   = valid_q;
    assign halt_fetch  = halt_q;

`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters. A stall that coincides with a flush is not
    // counted, because the flush wins.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
        if (stall && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule
